ppu_bg_shift_bank: RTL and testbench
====================================

// Module: ppu_bg_shift_bank
// PURPOSE
//  Parametrised bank of PLANES serial-out/parallel-load shift registers for the PPU background pipeline.
//  Each plane holds WIDTH bits, shifts right and is tapped at fine-X, so the pixel for one dot comes out every enabled cycle.
//  Pattern planes take a bit-reversed tile byte. Attribute ("fill") planes replicate a latched bit.
//  An internal phase counter can auto-reload the bank every 8 shifts, giving glue-free tile fetch/shift sequencing.
// PARAMETERS
//  WIDTH   16  bits per plane; must be >= 16 (8 visible + 8 preload)
//  PLANES  4   number of planes; must be >= 2 (planes 0/1 = pattern lo/hi)
// PORTS
//  i_clk          in   1           clock; all state updates on NEGEDGE
//  i_reset_n      in   1           reset, asynchronous, active-low
//  i_ce           in   1           clock enable; 0 = all state holds
//  i_shift        in   1           shift every plane right by one
//  i_load         in   1           explicit parallel load of top byte
//  i_auto_reload  in   1           1 = load automatically when phase wraps 7->0
//  i_phase_clear  in   1           force phase counter to 0
//  i_fill_mode    in   PLANES      per plane: 1 = attribute/fill plane, 0 = pattern plane
//  i_load_data    in   PLANES*8    byte p at [p*8+7:p*8]
//  i_fine_x       in   3           tap offset 0..7
//  o_pixel        out  PLANES      bit p = plane p [i_fine_x]
//  o_opaque       out  1           |o_pixel[1:0]
//  o_reload_ack   out  1           one-ce-cycle pulse after an auto-load
//  o_phase        out  3           current phase counter
//  o_debug_data   out  PLANES*WIDTH  raw plane contents, plane p at [p*WIDTH +: WIDTH]
// BEHAVIOUR
//  Reset: planes, fill latches, phase and o_reload_ack all 0. Hence o_pixel=0 and o_opaque=0.
//  Reset mid-operation aborts immediately. Nothing pending survives.
//  i_ce=0: no state changes. o_pixel still tracks i_fine_x combinationally.
//  Shift: r <= {msb_in, r[WIDTH-1:1]}. msb_in = 0 for pattern planes; msb_in = fill latch for fill planes.
//  Load (do_load = i_load | auto_load):
//   - Pattern plane: r[WIDTH-8+k] <= byte[7-k] for k=0..7, so the byte's MSB (leftmost pixel) exits first.
//   - Fill plane: latch <= byte[0] and r[WIDTH-1:WIDTH-8] <= {8{byte[0]}}.
//   - Bits [WIDTH-9:0] are untouched by a load.
//  Shift+load in the same cycle: shift applies first, then the load overwrites the top byte.
//   The loaded byte is never shifted that cycle.
//  Phase: increments mod 8 on each shift.
//   - Clear without shift: phase <= 0.
//   - Clear with shift: phase <= 0, and clear wins over the increment.
//  auto_load = i_auto_reload & i_shift & (phase==7) & ~i_phase_clear.
//  i_load together with auto_load: a single load from the same i_load_data, no double effect.
//   o_reload_ack still pulses.
//  o_reload_ack: 1 on the ce cycle after an auto_load, 0 on the next ce cycle. An explicit i_load alone never asserts it.
//  i_fine_x is combinational into o_pixel; a change is visible the same cycle.
//  Width rules: no arithmetic beyond the 3-bit wrap of phase; all indices are in range because WIDTH >= 16.
// TESTING
//  1. Reset while the planes are full -> o_debug_data=0, o_phase=0, o_reload_ack=0 asynchronously, before any clock edge.
//  2. Pattern load 8'hA5 into plane0, fine_x=0, then 16 shifts -> o_pixel[0] sequence 1,0,1,0,0,1,0,1 after 8 shifts, then 0s.
//  3. Fill plane load byte 8'h01, 16 shifts -> o_pixel[2]=1 throughout, because the latch refills the MSB.
//  4. i_auto_reload=1, continuous shift, data changing every 8 -> seamless pixel stream.
//     o_reload_ack pulses once per 8 shifts, one cycle after phase 7.
//  5. Phase 7 with i_shift, i_phase_clear and i_auto_reload together -> no load, phase=0, no ack.
//     Repeat with i_load=1 -> one load, no ack.
//  6. i_ce toggled 0/1 every cycle during test 4 -> identical pixel sequence at half rate. Ack width is exactly one ce cycle.

Source files
------------

// File: rtl/ppu_bg_shift_bank.sv
// ppu_bg_shift_bank: bank of right-shifting background planes tapped at fine-X, with optional
// self-sequenced reload every 8 shifts so tile fetch needs no external phase logic.
module ppu_bg_shift_bank #(
    parameter int WIDTH  = 16,
    parameter int PLANES = 4
) (
    input  logic                      i_clk,
    input  logic                      i_reset_n,
    input  logic                      i_ce,
    input  logic                      i_shift,
    input  logic                      i_load,
    input  logic                      i_auto_reload,
    input  logic                      i_phase_clear,
    input  logic [PLANES-1:0]         i_fill_mode,
    input  logic [PLANES*8-1:0]       i_load_data,
    input  logic [2:0]                i_fine_x,
    output logic [PLANES-1:0]         o_pixel,
    output logic                      o_opaque,
    output logic                      o_reload_ack,
    output logic [2:0]                o_phase,
    output logic [PLANES*WIDTH-1:0]   o_debug_data
);
    logic [2:0] r_phase;
    logic       r_ack;
    logic       w_auto_load;
    logic       w_do_load;

    // A phase clear suppresses the wrap reload even when it coincides with phase 7.
    assign w_auto_load = i_auto_reload & i_shift & (r_phase == 3'd7) & ~i_phase_clear;
    assign w_do_load   = i_load | w_auto_load;

    always_ff @(negedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_phase <= 3'd0;
            r_ack   <= 1'b0;
        end else if (i_ce) begin
            r_phase <= i_phase_clear ? 3'd0 : r_phase + {2'b00, i_shift};
            r_ack   <= w_auto_load;
        end
    end

    genvar p;
    generate
        for (p = 0; p < PLANES; p++) begin : g_plane
            logic [WIDTH-1:0] r_plane;
            logic             r_fill;
            logic [WIDTH-1:0] w_shifted;
            logic [WIDTH-1:0] w_next;
            logic [7:0]       w_byte;
            logic [7:0]       w_top;
            logic [7:0]       w_low;

            assign w_byte = i_load_data[p*8 +: 8];
            assign w_low  = r_plane[7:0];

            // Shift happens first; a load then overwrites only the top byte.
            always_comb begin
                for (int k = 0; k < 8; k++)
                    w_top[k] = i_fill_mode[p] ? w_byte[0] : w_byte[7-k];
                w_shifted = i_shift ? {i_fill_mode[p] & r_fill, r_plane[WIDTH-1:1]} : r_plane;
                w_next    = w_do_load ? {w_top, w_shifted[WIDTH-9:0]} : w_shifted;
            end

            always_ff @(negedge i_clk or negedge i_reset_n) begin
                if (!i_reset_n) begin
                    r_plane <= '0;
                    r_fill  <= 1'b0;
                end else if (i_ce) begin
                    r_plane <= w_next;
                    if (w_do_load)
                        r_fill <= w_byte[0];
                end
            end

            assign o_pixel[p]                     = w_low[i_fine_x];
            assign o_debug_data[p*WIDTH +: WIDTH] = r_plane;
        end
    endgenerate

    assign o_opaque     = |o_pixel[1:0];
    assign o_reload_ack = r_ack;
    assign o_phase      = r_phase;
endmodule

// File: tb/tb_ppu_bg_shift_bank.sv
// tb_ppu_bg_shift_bank: directed vectors with a queued scoreboard; a monitor pops and compares
// each expectation shortly after the negedge on which the DUT updated.
module tb_ppu_bg_shift_bank;
    logic        clk, rst_n, ce, sh, ld, ar, clr;
    logic [3:0]  fill;
    logic [31:0] data;
    logic [2:0]  fx;
    logic [3:0]  pix;
    logic        opq, ack;
    logic [2:0]  ph;
    logic [63:0] dbg;

    typedef struct {
        string      nm;
        logic [3:0] pm;
        logic [3:0] px;
        int         ph;
        int         ack;
        int         d0;
    } exp_t;

    exp_t        q[$];
    int          vec = 0;
    int          err = 0;
    logic [7:0]  a, b;
    logic [7:0]  x[5];
    logic [31:0] p0s, p1s;

    ppu_bg_shift_bank #(.WIDTH(16), .PLANES(4)) dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_ce(ce), .i_shift(sh), .i_load(ld),
        .i_auto_reload(ar), .i_phase_clear(clr), .i_fill_mode(fill), .i_load_data(data),
        .i_fine_x(fx), .o_pixel(pix), .o_opaque(opq), .o_reload_ack(ack), .o_phase(ph),
        .o_debug_data(dbg)
    );

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    task automatic chk(string nm, logic [63:0] act, logic [63:0] expv);
        vec++;
        if (act !== expv) begin
            err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, expv);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            while (q.size() > 0) begin
                e = q.pop_front();
                if (e.pm != 4'h0) chk({e.nm, "_pix"}, 64'(pix & e.pm), 64'(e.px & e.pm));
                if (e.pm[1:0] == 2'b11) chk({e.nm, "_opq"}, 64'(opq), 64'(e.px[0] | e.px[1]));
                if (e.ph >= 0) chk({e.nm, "_phase"}, 64'(ph), 64'(e.ph));
                if (e.ack >= 0) chk({e.nm, "_ack"}, 64'(ack), 64'(e.ack));
                if (e.d0 >= 0) chk({e.nm, "_plane0"}, 64'(dbg[15:0]), 64'(e.d0));
            end
        end
    end

    task automatic go(logic c, logic s, logic l, logic r, logic k, logic [2:0] f, logic [31:0] d,
                      string nm, logic [3:0] pm, logic [3:0] px, int pp, int pa, int d0);
        exp_t e;
        ce = c; sh = s; ld = l; ar = r; clr = k; fx = f; data = d;
        e.nm = nm; e.pm = pm; e.px = px; e.ph = pp; e.ack = pa; e.d0 = d0;
        q.push_back(e);
        @(posedge clk);
    endtask

    function automatic logic [3:0] pexp(int n);
        logic p0, p1;
        if (n < 8) begin
            p0 = a[3'(n)];
            p1 = b[3'(n)];
        end else begin
            p0 = x[(n-8)/8][3'(7-(n-8)%8)];
            p1 = 1'b0;
        end
        return {1'b0, 1'b1, p1, p0};
    endfunction

    // Leaves plane0=0x00A5, plane1=0x002D, plane2=0xFFFF (latch 1), plane3=0, phase 0.
    task automatic setup();
        go(1, 0, 1, 0, 1, 0, 32'h0001B4A5, "setup_ld", 4'h0, 4'h0, 0, -1, -1);
        for (int i = 1; i <= 8; i++)
            go(1, 1, 0, 0, 0, 0, 32'h0001B4A5, "setup_sh", 4'h0, 4'h0, i % 8, 0, -1);
    endtask

    task automatic stream(logic half);
        setup();
        go(1, 0, 1, 1, 0, 0, {24'h000100, x[0]}, "stream_ld", 4'hF, pexp(0), 0, 0, -1);
        for (int n = 1; n <= 32; n++) begin
            if (half)
                go(0, 1, 0, 1, 0, 0, {24'h000100, x[n/8]}, "stream_hold", 4'hF, pexp(n-1),
                   (n-1) % 8, ((n-1) % 8 == 0 && n > 1) ? 1 : 0, -1);
            go(1, 1, 0, 1, 0, 0, {24'h000100, x[n/8]}, half ? "stream_half" : "stream",
               4'hF, pexp(n), n % 8, (n % 8 == 0) ? 1 : 0, -1);
        end
    endtask

    task automatic wrap_case(logic k, logic l, int d0, int pa, string nm);
        setup();
        for (int i = 1; i <= 7; i++)
            go(1, 1, 0, 0, 0, 0, 32'h0001000F, "pre_wrap", 4'h0, 4'h0, i, -1, -1);
        go(1, 1, l, 1, k, 0, 32'h0001000F, nm, 4'h0, 4'h0, 0, pa, d0);
    endtask

    initial begin
        a = 8'hA5; b = 8'h2D; p0s = 32'h0000A500; p1s = 32'h00002D00;
        x[0] = 8'h1E; x[1] = 8'hC4; x[2] = 8'h6B; x[3] = 8'h3A; x[4] = 8'hF1;
        rst_n = 1'b0; ce = 0; sh = 0; ld = 0; ar = 0; clr = 0; fx = 0; data = 0;
        fill = 4'b1100;
        repeat (2) @(posedge clk);
        rst_n = 1'b1;
        go(0, 0, 0, 0, 0, 0, 32'h0, "reset", 4'hF, 4'h0, 0, 0, 0);

        go(1, 0, 1, 0, 0, 0, 32'h0001B4A5, "ld_pat", 4'hF, 4'h0, 0, 0, 16'hA500);
        for (int n = 1; n <= 16; n++)
            go(1, 1, 0, 0, 0, 0, 32'h0001B4A5, "shift_pat", 4'hF,
               {1'b0, n >= 8, p1s[5'(n)], p0s[5'(n)]}, n % 8, 0, -1);

        setup();
        for (int k = 0; k < 8; k++)
            go(0, 1, 1, 1, 1, 3'(k), 32'hFFFFFFFF, "fx_hold", 4'hF,
               {1'b0, 1'b1, b[3'(k)], a[3'(k)]}, 0, 0, 16'h00A5);

        stream(1'b0);
        stream(1'b1);

        wrap_case(1'b1, 1'b0, 16'h0000, 0, "clr_wrap");
        go(1, 0, 0, 0, 0, 0, 32'h0, "clr_wrap_next", 4'h0, 4'h0, 0, 0, 16'h0000);
        wrap_case(1'b1, 1'b1, 16'hF000, 0, "clr_ld_wrap");
        go(1, 0, 0, 0, 0, 0, 32'h0, "clr_ld_next", 4'h0, 4'h0, 0, 0, 16'hF000);
        wrap_case(1'b0, 1'b1, 16'hF000, 1, "ld_auto_wrap");

        // Reset mid-cycle while planes are loaded and the ack is high.
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_dbg", dbg, 64'h0);
        chk("async_rst_phase", 64'(ph), 64'h0);
        chk("async_rst_ack", 64'(ack), 64'h0);
        chk("async_rst_pix", 64'(pix), 64'h0);
        @(posedge clk);
        rst_n = 1'b1;
        go(1, 0, 0, 0, 0, 0, 32'h0, "post_rst", 4'hF, 4'h0, 0, 0, 0);

        @(negedge clk);
        #3;
        if (q.size() != 0) begin
            err++;
            $display("FAIL drain: got %0d pending, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end
endmodule
